// File: rtl/symbol_shift_pkg.sv
// Shared types and helpers for the symbol shifter: mode encoding, symbol slice
// extraction and parameter legality checks. No logic, no latency, no handshake.
package symbol_shift_pkg;

  typedef enum logic [1:0] {
    SHM_LSR = 2'b00,
    SHM_LSL = 2'b01,
    SHM_ROR = 2'b10,
    SHM_ASR = 2'b11
  } shm_e;

  localparam int SLICE_VEC_MAX = 1024;
  localparam int SLICE_SYM_MAX = 32;

  // Symbol idx of a zero-extended vector, right-aligned in the return value.
  function automatic logic [SLICE_SYM_MAX-1:0] sym_slice(
    input logic [SLICE_VEC_MAX-1:0] vec,
    input int                       idx,
    input int                       sym_w
  );
    logic [SLICE_VEC_MAX-1:0] sh;
    sh = vec >> (idx * sym_w);
    return sh[SLICE_SYM_MAX-1:0] & ~({SLICE_SYM_MAX{1'b1}} << sym_w);
  endfunction

  function automatic bit params_legal(
    input int sym_w,
    input int num_sym,
    input int max_shift,
    input int shift_w
  );
    return (sym_w >= 1) && (sym_w <= SLICE_SYM_MAX) &&
           (num_sym >= 2) && (num_sym * sym_w <= SLICE_VEC_MAX) &&
           (max_shift >= 0) && (max_shift < num_sym) &&
           (shift_w >= 1) && (shift_w < 31) && ((1 << shift_w) > max_shift);
  endfunction

endpackage

// File: rtl/symbol_shift_stage.sv
// Combinational shift by 0 or STEP symbols in the selected mode; vacated slots take fill.
// Zero latency, no handshake: the enclosing pipeline owns flow control.
module symbol_shift_stage
  import symbol_shift_pkg::*;
#(
  parameter int SYM_W   = 5,
  parameter int NUM_SYM = 10,
  parameter int STEP    = 1
) (
  input  logic [NUM_SYM*SYM_W-1:0] din,
  input  shm_e                     mode,
  input  logic [SYM_W-1:0]         fill,
  input  logic                     en,
  output logic [NUM_SYM*SYM_W-1:0] dout
);

  for (genvar j = 0; j < NUM_SYM; j++) begin : g_sym
    localparam int ROT_IDX = (j + STEP) % NUM_SYM;
    logic [SYM_W-1:0] rsh;
    logic [SYM_W-1:0] lsh;
    logic [SYM_W-1:0] rot;
    logic [SYM_W-1:0] sym;

    if (j + STEP < NUM_SYM) begin : g_rsh
      assign rsh = din[(j+STEP)*SYM_W +: SYM_W];
    end else begin : g_rsh_fill
      assign rsh = fill;
    end

    if (j >= STEP) begin : g_lsh
      assign lsh = din[(j-STEP)*SYM_W +: SYM_W];
    end else begin : g_lsh_fill
      assign lsh = fill;
    end

    assign rot = din[ROT_IDX*SYM_W +: SYM_W];

    // Arithmetic right reuses the logical path; the caller supplies the top symbol as fill.
    always_comb begin
      sym = din[j*SYM_W +: SYM_W];
      if (en) begin
        case (mode)
          SHM_LSR: sym = rsh;
          SHM_LSL: sym = lsh;
          SHM_ROR: sym = rot;
          SHM_ASR: sym = rsh;
          default: sym = rsh;
        endcase
      end
    end

    assign dout[j*SYM_W +: SYM_W] = sym;
  end

endmodule

// File: rtl/symbol_shifter_pipe.sv
// Pipelined symbol shifter (LSR/LSL/ROR/ASR) with saturating out-of-range counter.
// Latency 2 cycles, 1 beat/cycle; in_ready = !s1_vld || s2 loads, so a stalled output backs up both stages.
module symbol_shifter_pipe
  import symbol_shift_pkg::*;
#(
  parameter int SYM_W     = 5,
  parameter int NUM_SYM   = 10,
  parameter int MAX_SHIFT = 4,
  parameter int SHIFT_W   = 3,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SYM*SYM_W-1:0] in_data,
  input  logic [SHIFT_W-1:0]       in_shift,
  input  logic [1:0]               in_mode,
  input  logic [SYM_W-1:0]         in_fill,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_SYM*SYM_W-1:0] out_data,
  output logic                     out_oor,
  output logic [CNT_W-1:0]         oor_count
);

  localparam int W = NUM_SYM * SYM_W;
  localparam logic [SHIFT_W-1:0] MAX_SHIFT_V = SHIFT_W'(MAX_SHIFT);

  if (!params_legal(SYM_W, NUM_SYM, MAX_SHIFT, SHIFT_W)) begin : g_bad_params
    $error("symbol_shifter_pipe: illegal parameter combination");
  end

  logic s1_vld;
  logic s2_vld;
  logic s1_load;
  logic s2_load;

  assign s2_load   = !s2_vld || out_ready;
  assign s1_load   = !s1_vld || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_vld;

  shm_e             in_mode_e;
  logic [SYM_W-1:0] top_sym;
  logic [SYM_W-1:0] fill_sel;
  logic             in_oor;

  assign in_mode_e = shm_e'(in_mode);
  assign top_sym   = SYM_W'(sym_slice(SLICE_VEC_MAX'(in_data), NUM_SYM - 1, SYM_W));
  assign fill_sel  = (in_mode_e == SHM_ASR) ? top_sym : in_fill;
  assign in_oor    = in_shift > MAX_SHIFT_V;

  // Stage 1: every shift bit above bit 0, one constant-step shifter per bit.
  logic [SHIFT_W-1:0][W-1:0] chain;
  assign chain[0] = in_data;

  for (genvar b = 1; b < SHIFT_W; b++) begin : g_s1
    symbol_shift_stage #(
      .SYM_W   (SYM_W),
      .NUM_SYM (NUM_SYM),
      .STEP    (1 << b)
    ) u_stage (
      .din  (chain[b-1]),
      .mode (in_mode_e),
      .fill (fill_sel),
      .en   (in_shift[b]),
      .dout (chain[b])
    );
  end

  logic [W-1:0]     s1_dat;
  shm_e             s1_mode;
  logic [SYM_W-1:0] s1_fill;
  logic             s1_oor;
  logic             s1_sh0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_dat  <= '0;
      s1_mode <= SHM_LSR;
      s1_fill <= '0;
      s1_oor  <= 1'b0;
      s1_sh0  <= 1'b0;
    end else if (s1_load) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_dat  <= in_oor ? {NUM_SYM{fill_sel}} : chain[SHIFT_W-1];
        s1_mode <= in_mode_e;
        s1_fill <= fill_sel;
        s1_oor  <= in_oor;
        s1_sh0  <= in_shift[0];
      end
    end
  end

  // Stage 2: the single-symbol step; an out-of-range beat is already a uniform word.
  logic [W-1:0] s2_dat;

  symbol_shift_stage #(
    .SYM_W   (SYM_W),
    .NUM_SYM (NUM_SYM),
    .STEP    (1)
  ) u_s2_stage (
    .din  (s1_dat),
    .mode (s1_mode),
    .fill (s1_fill),
    .en   (s1_sh0 && !s1_oor),
    .dout (s2_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld   <= 1'b0;
      out_data <= '0;
      out_oor  <= 1'b0;
    end else if (s2_load) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        out_data <= s2_dat;
        out_oor  <= s1_oor;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oor_count <= '0;
    end else if (out_valid && out_ready && out_oor && (oor_count != {CNT_W{1'b1}})) begin
      oor_count <= oor_count + 1'b1;
    end
  end

endmodule
